// File: rtl/dma_copy.sv
// dma_copy: word-copy bus initiator. On a start pulse it reads a block of
// 32-bit words from a source range and writes them to a destination range,
// one read then one write per word, with an optional per-request timeout.
module dma_copy #(
   parameter int TIMEOUT = 64,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        src_addr,
   input  logic [31:0]        dst_addr,
   input  logic [COUNT_W-1:0] word_count,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic               read,
   output logic               write,
   output logic [31:0]        address,
   output logic [31:0]        write_data,
   input  logic [31:0]        read_data,
   input  logic               response
);

   // Wait counter only needs to reach TIMEOUT-1; keep it at least one bit wide.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      FINISH
   } state_t;

   state_t             state_reg;
   logic [31:0]        src_reg;
   logic [31:0]        dst_reg;
   logic [COUNT_W-1:0] remaining_reg;
   logic [WAIT_W-1:0]  wait_reg;
   logic               timed_out;

   // Abort when the current request has gone unanswered for TIMEOUT cycles,
   // counting this one. A zero TIMEOUT disables the check entirely.
   assign timed_out = (TIMEOUT > 0) && !response && (wait_reg == WAIT_LAST);

   // Transfer sequencer; all bus and status outputs are registered here.
   // write_data doubles as the data register holding the word just read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         read          <= 1'b0;
         write         <= 1'b0;
         address       <= '0;
         write_data    <= '0;
         src_reg       <= '0;
         dst_reg       <= '0;
         remaining_reg <= '0;
         wait_reg      <= '0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  src_reg       <= src_addr;
                  dst_reg       <= dst_addr;
                  remaining_reg <= word_count;
                  error         <= 1'b0;
                  if (word_count == '0) begin
                     // Empty transfer: report completion without touching the bus.
                     state_reg <= FINISH;
                     done      <= 1'b1;
                  end else begin
                     state_reg <= READ;
                     busy      <= 1'b1;
                     read      <= 1'b1;
                     address   <= src_addr;
                     wait_reg  <= '0;
                  end
               end
            end
            READ: begin
               if (response) begin
                  write_data <= read_data;
                  src_reg    <= src_reg + 32'd4;
                  read       <= 1'b0;
                  write      <= 1'b1;
                  address    <= dst_reg;
                  wait_reg   <= '0;
                  state_reg  <= WRITE;
               end else if (timed_out) begin
                  state_reg <= FINISH;
                  done      <= 1'b1;
                  error     <= 1'b1;
                  busy      <= 1'b0;
                  read      <= 1'b0;
               end else begin
                  wait_reg <= wait_reg + 1'b1;
               end
            end
            WRITE: begin
               if (response) begin
                  dst_reg       <= dst_reg + 32'd4;
                  remaining_reg <= remaining_reg - 1'b1;
                  write         <= 1'b0;
                  if (remaining_reg == COUNT_W'(1)) begin
                     state_reg <= FINISH;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     // src_reg was already advanced when the read completed.
                     state_reg <= READ;
                     read      <= 1'b1;
                     address   <= src_reg;
                     wait_reg  <= '0;
                  end
               end else if (timed_out) begin
                  state_reg <= FINISH;
                  done      <= 1'b1;
                  error     <= 1'b1;
                  busy      <= 1'b0;
                  write     <= 1'b0;
               end else begin
                  wait_reg <= wait_reg + 1'b1;
               end
            end
            FINISH: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: randomized self-checking bench for dma_copy with a memory
// responder (configurable wait states / stalled address) and a word-level
// copy model that predicts bus transactions, final memory and done timing.
module tb_dma_copy;

   localparam int TIMEOUT = 4;
   localparam int COUNT_W = 16;

   logic               clk;
   logic               reset;
   logic               start;
   logic [31:0]        src_addr;
   logic [31:0]        dst_addr;
   logic [COUNT_W-1:0] word_count;
   logic               busy;
   logic               done;
   logic               error;
   logic               read;
   logic               write;
   logic [31:0]        address;
   logic [31:0]        write_data;
   logic [31:0]        read_data;
   logic               response;

   dma_copy #(.TIMEOUT(TIMEOUT), .COUNT_W(COUNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .read       (read),
      .write      (write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .response   (response)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Responder memory: 256 words, indexed by byte address bits [9:2].
   logic [31:0] mem     [0:255];
   logic [31:0] ref_mem [0:255];

   int          wait_n     = 0;
   bit          stall_en   = 1'b0;
   logic [31:0] stall_addr = 32'h0;
   int          hold_cnt;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t log_q[$];
   txn_t exp_q[$];

   assign read_data = mem[address[9:2]];
   assign response  = (read || write) && (hold_cnt >= wait_n) &&
                      !(stall_en && read && (address == stall_addr));

   // Count how long the current request has been held without an answer.
   always @(posedge clk) begin
      if (response)
         hold_cnt <= 0;
      else if (read || write)
         hold_cnt <= hold_cnt + 1;
      else
         hold_cnt <= 0;
   end

   // Results of the most recent run_xfer.
   int   done_k, max_rd_run, busy_bad, stab_bad, excl_bad, rd_cycles, wr_cycles;
   logic done_after, err_at_done, err_k1, req_at_done;

   // Word-by-word copy model: expected bus transactions and final memory.
   function automatic void build_model(input logic [31:0] s, input logic [31:0] d, input int n);
      logic [31:0] a_s, a_d, w;
      txn_t t;
      ref_mem = mem;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a_s = s + 32'(4 * i);
         a_d = d + 32'(4 * i);
         w   = ref_mem[a_s[9:2]];
         t.wr = 1'b0; t.addr = a_s; t.data = w;
         exp_q.push_back(t);
         ref_mem[a_d[9:2]] = w;
         t.wr = 1'b1; t.addr = a_d; t.data = w;
         exp_q.push_back(t);
      end
   endfunction

   function automatic int log_diffs();
      int d = 0;
      if (log_q.size() != exp_q.size()) d++;
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         if (log_q[i] !== exp_q[i]) d++;
      return d;
   endfunction

   function automatic int mem_diffs();
      int d = 0;
      for (int i = 0; i < 256; i++)
         if (mem[i] !== ref_mem[i]) d++;
      return d;
   endfunction

   // Pulse start and observe every cycle until done (bounded), logging
   // acknowledged transactions and committing writes to the memory.
   task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int n, input bit poke);
      int          k;
      int          rd_run;
      bit          pend;
      logic [65:0] prev_bus;
      txn_t        t;
      k = 0; rd_run = 0; pend = 1'b0; prev_bus = '0;
      done_k = -1; max_rd_run = 0; busy_bad = 0; stab_bad = 0; excl_bad = 0;
      rd_cycles = 0; wr_cycles = 0;
      done_after = 1'b0; err_at_done = 1'b0; err_k1 = 1'b0; req_at_done = 1'b0;
      log_q.delete();
      @(negedge clk);
      src_addr = s; dst_addr = d; word_count = COUNT_W'(n); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (k < 400) begin
         k++;
         if (k == 1) err_k1 = error;
         if (poke && k == 2) begin
            start = 1'b1; src_addr = 32'h3F0; dst_addr = 32'h3F8; word_count = COUNT_W'(1);
         end else begin
            start = 1'b0;
         end
         if (read && write) excl_bad++;
         if (pend && ({read, write, address, write_data} !== prev_bus)) stab_bad++;
         if (done === 1'b1) begin
            done_k = k; err_at_done = error; req_at_done = read | write;
            if (busy !== 1'b0) busy_bad++;
            break;
         end
         if (busy !== (n != 0)) busy_bad++;
         if (read) begin
            rd_cycles++; rd_run++;
            if (rd_run > max_rd_run) max_rd_run = rd_run;
         end else begin
            rd_run = 0;
         end
         if (write) wr_cycles++;
         if (response && (read || write)) begin
            t.wr = write; t.addr = address; t.data = write ? write_data : read_data;
            log_q.push_back(t);
            if (write) mem[address[9:2]] = write_data;
         end
         pend = (read || write) && !response;
         prev_bus = {read, write, address, write_data};
         @(negedge clk);
      end
      start = 1'b0;
      if (done_k >= 0) begin
         @(negedge clk);
         done_after = done;
      end
      $display("[TB] xfer src=%h dst=%h n=%0d wait=%0d -> done_cycle=%0d error=%0b bus_txns=%0d",
               s, d, n, wait_n, done_k, err_at_done, log_q.size());
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if ({busy, done, error} !== 3'b000) begin fails++; $display("FAIL reset_status: got %b expected 000", {busy, done, error}); end
      tests++; if ({read, write} !== 2'b00) begin fails++; $display("FAIL reset_req: got %b expected 00", {read, write}); end
      tests++; if (address !== 32'h0) begin fails++; $display("FAIL reset_address: got %h expected 00000000", address); end
      tests++; if (write_data !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h expected 00000000", write_data); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_plan_copy();
      wait_n = 0;
      mem[32'h100 >> 2] = 32'hA; mem[32'h104 >> 2] = 32'hB; mem[32'h108 >> 2] = 32'hC;
      build_model(32'h100, 32'h200, 3);
      run_xfer(32'h100, 32'h200, 3, 1'b0);
      tests++; if (done_k !== 7) begin fails++; $display("FAIL plan_done_cycle: got %0d expected 7", done_k); end
      tests++; if (err_at_done !== 1'b0) begin fails++; $display("FAIL plan_error: got %b expected 0", err_at_done); end
      tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL plan_bus_seq: got %0d differing txns expected 0", log_diffs()); end
      tests++; if ({mem[32'h200 >> 2], mem[32'h204 >> 2], mem[32'h208 >> 2]} !== {32'hA, 32'hB, 32'hC})
         begin fails++; $display("FAIL plan_dst_mem: got %h %h %h expected a b c", mem[128], mem[129], mem[130]); end
      tests++; if (busy_bad !== 0) begin fails++; $display("FAIL plan_busy: got %0d bad cycles expected 0", busy_bad); end
      tests++; if (done_after !== 1'b0) begin fails++; $display("FAIL plan_done_pulse: got done=%b after pulse expected 0", done_after); end
   endtask

   task automatic test_wait_states();
      logic [31:0] s, d;
      wait_n = 2;
      s = 32'($urandom_range(0, 100)) * 4;
      d = (32'd128 + 32'($urandom_range(0, 100))) * 4;
      build_model(s, d, 2);
      run_xfer(s, d, 2, 1'b0);
      tests++; if (done_k !== 13) begin fails++; $display("FAIL wait_done_cycle: got %0d expected 13", done_k); end
      tests++; if (stab_bad !== 0) begin fails++; $display("FAIL wait_stable: got %0d unstable cycles expected 0", stab_bad); end
      tests++; if ({rd_cycles, wr_cycles} !== {32'd6, 32'd6}) begin fails++; $display("FAIL wait_req_cycles: got rd=%0d wr=%0d expected 6 6", rd_cycles, wr_cycles); end
      tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL wait_bus_seq: got %0d differing txns expected 0", log_diffs()); end
      tests++; if (mem_diffs() !== 0) begin fails++; $display("FAIL wait_mem: got %0d differing words expected 0", mem_diffs()); end
   endtask

   task automatic test_empty();
      wait_n = 0;
      build_model(32'h20, 32'h220, 0);
      run_xfer(32'h20, 32'h220, 0, 1'b0);
      tests++; if (done_k !== 1) begin fails++; $display("FAIL empty_done_cycle: got %0d expected 1", done_k); end
      tests++; if (rd_cycles + wr_cycles !== 0 || log_q.size() !== 0) begin fails++; $display("FAIL empty_no_bus: got %0d request cycles expected 0", rd_cycles + wr_cycles); end
      tests++; if (busy_bad !== 0) begin fails++; $display("FAIL empty_busy: got %0d bad cycles expected 0", busy_bad); end
   endtask

   task automatic test_wrap();
      wait_n = 0;
      build_model(32'hFFFF_FFFC, 32'h10, 2);
      run_xfer(32'hFFFF_FFFC, 32'h10, 2, 1'b0);
      tests++;
      if (log_q.size() !== 4) begin
         fails++; $display("FAIL wrap_count: got %0d txns expected 4", log_q.size());
      end else if ({log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[3].addr} !==
                   {32'hFFFF_FFFC, 32'h10, 32'h0, 32'h14}) begin
         fails++; $display("FAIL wrap_addrs: got %h %h %h %h expected fffffffc 00000010 00000000 00000014",
                           log_q[0].addr, log_q[1].addr, log_q[2].addr, log_q[3].addr);
      end
      tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL wrap_bus_seq: got %0d differing txns expected 0", log_diffs()); end
      tests++; if (mem_diffs() !== 0) begin fails++; $display("FAIL wrap_mem: got %0d differing words expected 0", mem_diffs()); end
   endtask

   task automatic test_random();
      logic [31:0] s, d;
      int n;
      for (int it = 0; it < 8; it++) begin
         wait_n = $urandom_range(0, 2);
         n = $urandom_range(1, 6);
         s = 32'($urandom_range(0, 120)) * 4;
         d = (32'd128 + 32'($urandom_range(0, 120))) * 4;
         build_model(s, d, n);
         run_xfer(s, d, n, 1'b0);
         tests++; if (done_k !== 2 * n * (wait_n + 1) + 1) begin fails++; $display("FAIL rand_done_cycle: got %0d expected %0d", done_k, 2 * n * (wait_n + 1) + 1); end
         tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL rand_bus_seq: got %0d differing txns expected 0", log_diffs()); end
         tests++; if (mem_diffs() !== 0) begin fails++; $display("FAIL rand_mem: got %0d differing words expected 0", mem_diffs()); end
         tests++; if (busy_bad + stab_bad + excl_bad !== 0) begin fails++; $display("FAIL rand_protocol: got busy=%0d stable=%0d excl=%0d expected 0 0 0", busy_bad, stab_bad, excl_bad); end
      end
   endtask

   task automatic test_timeout();
      wait_n = 0;
      stall_en = 1'b1; stall_addr = 32'h44;
      build_model(32'h40, 32'h300, 1);
      run_xfer(32'h40, 32'h300, 3, 1'b0);
      tests++; if (done_k !== 7) begin fails++; $display("FAIL timeout_done_cycle: got %0d expected 7", done_k); end
      tests++; if (err_at_done !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b expected 1", err_at_done); end
      tests++; if (max_rd_run !== TIMEOUT) begin fails++; $display("FAIL timeout_read_hold: got %0d cycles expected %0d", max_rd_run, TIMEOUT); end
      tests++; if (req_at_done !== 1'b0) begin fails++; $display("FAIL timeout_req_drop: got %b expected 0", req_at_done); end
      tests++; if (log_diffs() !== 0 || mem_diffs() !== 0) begin fails++; $display("FAIL timeout_partial: got %0d txn and %0d mem diffs expected 0 0", log_diffs(), mem_diffs()); end
      tests++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b expected 1", error); end
      stall_en = 1'b0;
      build_model(32'h80, 32'h320, 2);
      run_xfer(32'h80, 32'h320, 2, 1'b0);
      tests++; if (err_k1 !== 1'b0) begin fails++; $display("FAIL timeout_error_clear: got %b expected 0", err_k1); end
      tests++; if (done_k !== 5 || err_at_done !== 1'b0) begin fails++; $display("FAIL timeout_recover: got done_cycle=%0d error=%b expected 5 0", done_k, err_at_done); end
      tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL timeout_recover_seq: got %0d differing txns expected 0", log_diffs()); end
   endtask

   task automatic test_start_while_busy();
      wait_n = 1;
      build_model(32'h60, 32'h260, 2);
      run_xfer(32'h60, 32'h260, 2, 1'b1);
      tests++; if (done_k !== 9) begin fails++; $display("FAIL busy_start_done_cycle: got %0d expected 9", done_k); end
      tests++; if (log_diffs() !== 0) begin fails++; $display("FAIL busy_start_seq: got %0d differing txns expected 0", log_diffs()); end
      tests++; if (mem_diffs() !== 0) begin fails++; $display("FAIL busy_start_mem: got %0d differing words expected 0", mem_diffs()); end
   endtask

   task automatic test_reset_mid();
      int   k;
      logic saw_done, saw_act;
      k = 0;
      wait_n = 3;
      @(negedge clk);
      src_addr = 32'h10; dst_addr = 32'h210; word_count = COUNT_W'(2); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (write !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      tests++; if (write !== 1'b1) begin fails++; $display("FAIL reset_mid_reach_write: got write=%b expected 1", write); end
      reset = 1'b1;
      @(negedge clk);
      tests++; if ({busy, done, error, read, write} !== 5'b0) begin fails++; $display("FAIL reset_mid_status: got %b expected 00000", {busy, done, error, read, write}); end
      tests++; if ({address, write_data} !== 64'h0) begin fails++; $display("FAIL reset_mid_bus: got addr=%h wdata=%h expected 0 0", address, write_data); end
      reset = 1'b0;
      saw_done = 1'b0; saw_act = 1'b0;
      repeat (6) begin
         @(negedge clk);
         saw_done = saw_done | done;
         saw_act  = saw_act | busy | read | write;
      end
      tests++; if ({saw_done, saw_act} !== 2'b00) begin fails++; $display("FAIL reset_mid_quiet: got done=%b activity=%b expected 0 0", saw_done, saw_act); end
      $display("[TB] xfer reset during write -> outputs cleared, no done");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0;
      src_addr = '0; dst_addr = '0; word_count = '0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      test_reset();
      test_plan_copy();
      test_wait_states();
      test_empty();
      test_wrap();
      test_random();
      test_timeout();
      test_start_while_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dma_copy.md
# dma_copy

Word-copy engine that acts as the initiator on the core's memory-mapped peripheral bus, the same read/write/address/write_data/read_data/response handshake that peripherals such as the GPIO block answer as responders. On a start pulse it copies a block of 32-bit words from a source address range to a destination address range, one read followed by one write per word. It sits beside the CPU's data port behind the bus mux and is configured directly by wires from a control register block.

## Interface
- TIMEOUT, 64: max cycles a request may wait for response before abort; 0 disables the timeout
- COUNT_W, 16: width of word_count
---
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle start pulse; sampled only in IDLE
- src_addr  in  32  source byte address of first word
- dst_addr  in  32  destination byte address of first word
- word_count  in  COUNT_W  number of 32-bit words to copy
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of transfer (normal, empty or aborted)
- error  out  1  sticky: last transfer aborted by timeout
- read  out  1  bus read request
- write  out  1  bus write request
- address  out  32  bus byte address
- write_data  out  32  bus write data
- read_data  in  32  bus read data, valid when response=1 during a read
- response  in  1  responder acknowledge for the current request

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE: start=1 latches src_addr, dst_addr, word_count into internal src/dst/remaining, clears error. remaining=0 -> FINISH (no bus activity); else -> READ. start outside IDLE is ignored.
- READ: read=1, address=src. Cycle with response=1: capture read_data into the data register, src += 4, -> WRITE.
- WRITE: write=1, address=dst, write_data=data register. Cycle with response=1: dst += 4, remaining -= 1; remaining becomes 0 -> FINISH, else -> READ.
- FINISH: done=1 for exactly one cycle, -> IDLE.
- read and write never both 1. Request signals, address and write_data stay constant until the cycle response=1 is seen.
- response while no request is asserted: ignored.
- Address arithmetic modulo 2^32 (0xFFFFFFFC + 4 -> 0x00000000); no alignment checking, addresses are used as given.
- Timeout (TIMEOUT>0): wait counter clears on entry to READ/WRITE, increments each request cycle with response=0. If response is still 0 on the TIMEOUT-th consecutive request cycle: -> FINISH, error set to 1, remaining words discarded.
- error holds until the next accepted start or reset.

## Timing
- Reset values: busy=0, done=0, error=0, read=0, write=0, address=0, write_data=0; state IDLE. Reset mid-transfer aborts immediately at that edge, no done pulse.
- Start accepted at edge E: READ asserted in cycle E+1.
- Zero-wait responder (response combinational with request): one cycle per READ, one per WRITE; N words -> done asserted in cycle E+2N+1; busy=1 from E+1 through E+2N, 0 in the done cycle.
- Each wait cycle (response=0) extends the current phase by one cycle.
- address/write_data are registered outputs; in IDLE and FINISH read=write=0 and address/write_data hold their last value.
- word_count=0: done in cycle E+1, busy never asserted.
- Timeout: request visible for exactly TIMEOUT cycles, done=1 and error=1 in the following cycle, request deasserted in that cycle.

## Test plan
- Zero-wait memory model, src=0x100, dst=0x200, count=3, memory[0x100..0x108]=0xA,0xB,0xC -> memory[0x200..0x208]=0xA,0xB,0xC; bus sequence R100,W200,R104,W204,R108,W208; done in cycle E+7; error=0.
- Responder with 2 wait cycles per request, count=2 -> each request held 3 cycles with stable address/write_data; done in cycle E+13.
- count=0 -> done pulse in cycle E+1, read/write never asserted, busy stays 0.
- src=0xFFFFFFFC, dst=0x10, count=2 -> reads at 0xFFFFFFFC then 0x00000000; writes at 0x10, 0x14.
- TIMEOUT=4, responder never answers the second read -> read held exactly 4 cycles, then done=1, error=1; next start with a good responder clears error and completes.
- reset asserted during a WRITE, start pulsed during busy -> reset: all outputs 0 next cycle, no done; start during busy: ignored, transfer unchanged.
